// File: rtl/receiver_ip_core.sv
`timescale 1ns / 1ps
// Serial 8N1 receiver with a small RX FIFO behind an AXI4-Lite slave (RXDATA/STATUS/CTRL/CLEAR).
// Define RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module receiver_ip_core #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              rx_i,
  output logic                              irq_o,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef RX_PARITY_EN
    StParity,
`endif
    StStop
  } rx_state_e;

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic [17:0]     ctrl_q, ctrl_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic            irq_q, irq_d;
  logic            aw_ready_q, aw_ready_d, bvalid_q, bvalid_d;
  logic            ar_ready_q, ar_ready_d, rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [15:0] div_eff, bit_reload, half_reload;
  logic        en, irqen, fall, tick;
  logic        fifo_empty, fifo_full;
  logic        wr_hs, rd_hs, pop, push_req, push_ok, ovr_set, fe_set, pe_set;
  logic        clr_hit, flush;
  logic [1:0]  wr_addr, rd_addr;
  logic [31:0] status, rd_mux;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_WDATA[31:18], S_AXI_WSTRB[3]};

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign div_eff     = (ctrl_q[15:0] < 16'd4) ? 16'd4 : ctrl_q[15:0];
  assign bit_reload  = div_eff - 16'd1;
  // One less than DIV/2 so the start sample lands DIV/2 cycles after the edge is seen.
  assign half_reload = (div_eff >> 1) - 16'd1;
  assign en          = ctrl_q[16];
  assign irqen       = ctrl_q[17];
  assign fall        = prev_q & ~sync2_q;
  assign tick        = (cnt_q == 16'd0);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));

  assign wr_addr = S_AXI_AWADDR[3:2];
  assign rd_addr = S_AXI_ARADDR[3:2];
  assign wr_hs   = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs   = ar_ready_q & S_AXI_ARVALID;
  assign pop     = rd_hs & (rd_addr == 2'd0) & ~fifo_empty;
  assign clr_hit = wr_hs & (wr_addr == 2'd3) & S_AXI_WSTRB[0];
  assign flush   = clr_hit & S_AXI_WDATA[0];

  // Receive FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push_req  = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    if (state_q != StIdle) cnt_d = tick ? bit_reload : cnt_q - 16'd1;
    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d   = StStart;
          cnt_d     = half_reload;
          par_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          if (!sync2_q) begin
            state_d = StData;
            bit_d   = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef RX_PARITY_EN
          if (bit_q == 3'd7) state_d = StParity;
`else
          if (bit_q == 3'd7) state_d = StStop;
`endif
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (tick) begin
          par_bad_d = sync2_q ^ (^shift_q);
          pe_set    = sync2_q ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          if (!sync2_q)        fe_set   = 1'b1;
          else if (!par_bad_q) push_req = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) begin
      state_d  = StIdle;
      push_req = 1'b0;
      fe_set   = 1'b0;
      pe_set   = 1'b0;
    end
  end

  // FIFO and sticky flags; a pop on a full FIFO makes room for a same-cycle push
  always_comb begin
    push_ok  = push_req & (~fifo_full | pop);
    ovr_set  = push_req & fifo_full & ~pop;
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(push_ok) - CntW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    ovr_d = (ovr_q & ~(clr_hit & S_AXI_WDATA[2])) | ovr_set;
    fe_d  = (fe_q & ~(clr_hit & S_AXI_WDATA[3])) | fe_set;
    pe_d  = (pe_q & ~(clr_hit & S_AXI_WDATA[4])) | pe_set;
    irq_d = irqen & ~fifo_empty;
  end

  assign status = {21'b0, 3'(count_q), 3'b0, pe_q, fe_q, ovr_q, fifo_full, fifo_empty};

  always_comb begin
    rd_mux = 32'd0;
    unique case (rd_addr)
      2'd0: rd_mux = {24'b0, fifo_empty ? 8'h00 : mem_q[rd_ptr_q]};
      2'd1: rd_mux = status;
      2'd2: rd_mux = {14'b0, ctrl_q};
      2'd3: rd_mux = 32'd0;
    endcase
  end

  // AXI handshakes and CTRL writes
  always_comb begin
    aw_ready_d = ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    bvalid_d   = wr_hs | (bvalid_q & ~S_AXI_BREADY);
    ar_ready_d = ~ar_ready_q & S_AXI_ARVALID & ~rvalid_q;
    rvalid_d   = rd_hs | (rvalid_q & ~S_AXI_RREADY);
    rdata_d    = rd_hs ? rd_mux : rdata_q;
    ctrl_d     = ctrl_q;
    if (wr_hs && wr_addr == 2'd2) begin
      if (S_AXI_WSTRB[0]) ctrl_d[7:0]   = S_AXI_WDATA[7:0];
      if (S_AXI_WSTRB[1]) ctrl_d[15:8]  = S_AXI_WDATA[15:8];
      if (S_AXI_WSTRB[2]) ctrl_d[17:16] = S_AXI_WDATA[17:16];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      ctrl_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      irq_q      <= 1'b0;
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      ctrl_q     <= ctrl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      irq_q      <= irq_d;
      aw_ready_q <= aw_ready_d;
      bvalid_q   <= bvalid_d;
      ar_ready_q <= ar_ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= shift_q;
  end

  assign irq_o         = irq_q;
  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule

// File: doc/receiver_ip_core.md
# receiver_ip_core

- Serial 8-bit asynchronous receiver, the counterpart of the transmitter IP; one start bit, 8 data bits LSB first, one stop bit.
- Received bytes are buffered in a 4-entry FIFO.
- Control, status and data are exposed through an AXI4-Lite slave with four 32-bit registers at 0x0, 0x4, 0x8 and 0xC.
- The block sits behind the same AXI interconnect the transmitter uses; its `rx_i` connects to a transmitter `tx` line or a board pin.

## Interface

- `C_S_AXI_DATA_WIDTH`, 32 — AXI data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 4 — byte address width; only `S_AXI_ARADDR[3:2]` and `S_AXI_AWADDR[3:2]` are decoded.
- `FIFO_DEPTH`, 4 — RX FIFO entries; must be a power of two.
- `ACLK` in 1 — single clock.
- `ARESET` in 1 — synchronous, active-high reset.
- `rx_i` in 1 — serial input, asynchronous to `ACLK`, idles high.
- `irq_o` out 1 — level interrupt.
- `S_AXI_AWADDR` in 4, `S_AXI_AWPROT` in 3 (ignored), `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1 — write address channel.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1 — write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1 — write response channel.
- `S_AXI_ARADDR` in 4, `S_AXI_ARPROT` in 3 (ignored), `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1 — read address channel.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1 — read data channel.

## Operation

**Registers**
- 0x0 RXDATA (RO)
  - `[7:0]` = FIFO head; upper bits read 0.
  - A read while the FIFO is non-empty pops one entry.
  - A read while empty returns 0 and pops nothing.
- 0x4 STATUS (RO)
  - `[0]` empty, `[1]` full, `[2]` overrun, `[3]` frame error, `[4]` parity error, `[10:8]` fill count (0..4).
  - Bits `[4:2]` are sticky.
- 0x8 CTRL (RW, WSTRB honoured per byte lane)
  - `[15:0]` DIV = `ACLK` cycles per bit; values below 4 behave as 4.
  - `[16]` EN.
  - `[17]` IRQEN.
- 0xC CLEAR (WO, reads 0), write 1 to act:
  - `[0]` flushes the FIFO.
  - `[2]`, `[3]`, `[4]` clear the matching sticky flags.
- `irq_o` = IRQEN & !empty, registered.

**Input synchronisation**
- `rx_i` passes through a 2-flop synchroniser, reset to 1.
- A falling edge is detected on the synchronised signal.

**Receive FSM**
- IDLE: if EN and a falling edge is seen, load the bit counter with DIV/2 (floor) and go to START.
- START: when the counter expires, sample the line.
  - Low: go to DATA.
  - High: treat as a glitch and return to IDLE with no flag.
- DATA: sample every DIV cycles and shift LSB-first. After the 8th bit, go to PARITY (when compiled in) or STOP.
- PARITY: sample one bit and compare against even parity of the data.
- STOP: sample one bit, then return to IDLE the next cycle.
  - Low: set frame error; the byte is discarded.
  - High and parity OK: push the byte.
  - Push while full: byte dropped, overrun set; FIFO contents unchanged.
- Clearing EN mid-frame aborts the frame and returns the FSM to IDLE next cycle with no flag.
- A CTRL write mid-frame takes effect on the next counter reload.

**FIFO boundary conditions**
- Pop and push in the same cycle:
  - Non-empty FIFO: both occur and the count is unchanged.
  - Empty FIFO: the push occurs and the read returns 0.
  - Full FIFO: the pop frees the slot and the push succeeds with no overrun.
- Flush (CLEAR[0]) in the same cycle as a push: the flush wins and the FIFO ends empty.
- Read and write pointers wrap modulo FIFO_DEPTH.

**AXI**
- BRESP and RRESP are always OKAY (00).
- Writes to RO registers are accepted and ignored.

## Timing

**Reset values**
- All AXI READY and VALID outputs 0, `S_AXI_RDATA` 0, `S_AXI_BRESP`/`S_AXI_RRESP` 0.
- `irq_o` 0.
- CTRL 0x0000_0000, i.e. disabled with DIV treated as 4.
- FIFO empty, all flags 0, FSM in IDLE, synchroniser at 1.

**Write handshake**
- Accept only when AWVALID & WVALID & !BVALID.
- AWREADY and WREADY pulse high together for one cycle.
- The register updates on that edge.
- BVALID asserts the next cycle and holds until BREADY.

**Read handshake**
- Accept when ARVALID & !RVALID.
- ARREADY pulses for one cycle; the RXDATA pop happens on that edge.
- RVALID asserts the next cycle with RDATA stable, held until RREADY.

**Reception latency**
- The byte is visible in STATUS (empty=0) 1 cycle after the stop-bit sample.
- The stop-bit sample occurs at 2 (sync) + DIV/2 + 9·DIV cycles after the `rx_i` fall, plus DIV more with parity.

**Reset mid-transaction**
- Reset during a frame or an AXI transaction returns everything to reset values on the next edge.
- The outstanding response is dropped.

## Configuration

- `RX_PARITY_EN` defined: a PARITY state exists and frames are 11 bits (start, 8 data, even parity, stop).
  - A parity mismatch sets STATUS[4] and discards the byte.
- `RX_PARITY_EN` undefined: no PARITY state and frames are 10 bits.
  - STATUS[4] and CLEAR[4] are constant 0.

## Test plan

- Reset, then read 0x0/0x4/0x8/0xC → 0, 0x0000_0001, 0, 0; `irq_o`=0; BRESP/RRESP=OKAY.
- Write CTRL=0x0003_0010 (DIV=16, EN, IRQEN), drive byte 0xA5 at 16 clk/bit → STATUS=0x0000_0100, `irq_o`=1; read RXDATA → 0xA5; then STATUS=0x1 and `irq_o`=0.
- Send 5 bytes 0x01..0x05 without reading → STATUS=0x0000_0406 (full, overrun, count 4); reads return 0x01..0x04, then 0; write CLEAR=0x4 → overrun clears.
- Drive stop bit low on byte 0x3C → STATUS[3]=1, FIFO stays empty; drive a 3-cycle low glitch on idle line → no byte, no flag.
- Write CTRL with WSTRB=0b0001 and data 0xFFFF_FF08 over CTRL=0x0001_0010 → CTRL reads 0x0001_0008; clear EN mid-frame → FSM idle, no byte pushed.
- With `RX_PARITY_EN` defined: byte 0x07 with wrong parity bit 0 → STATUS[4]=1 and no byte; with correct parity 1 → 0x07 received.
